// File: rtl/adc_avg_display_if.sv
// Sample input and averaged/display output bundle for adc_avg_display.
interface adc_avg_display_if;
    logic        sample_valid;
    logic [15:0] sample;
    logic        avg_valid;
    logic [11:0] avg_out;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output sample_valid, sample,
        input  avg_valid, avg_out, an, seg, dp
    );

    modport slave (
        input  sample_valid, sample,
        output avg_valid, avg_out, an, seg, dp
    );
endinterface

// File: rtl/adc_avg_display.sv
// Boxcar-averages 2^AVG_LOG2 ADC samples and scans the latest result as hex
// on a 4-digit multiplexed seven-segment display.
module adc_avg_display #(
    parameter int unsigned AVG_LOG2    = 4,
    parameter int unsigned REFRESH_DIV = 125000
) (
    input  logic              clk,
    input  logic              rst,
    adc_avg_display_if.slave  bus
);

    localparam int unsigned ACC_W = 16;
    localparam int unsigned CNT_W = AVG_LOG2;
    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [11:0]      avg_out;
    logic             avg_valid;
    logic [15:0]      disp;
    logic [REF_W-1:0] refresh;
    logic [1:0]       idx;
    logic [3:0]       an;
    logic [6:0]       seg;
    logic             dp;

    logic [ACC_W-1:0] sum_c;
    logic [11:0]      avg_c;
    logic             last_c;
    logic [1:0]       idx_next_c;
    logic [3:0]       nib_c;
    logic [6:0]       seg_next_c;

    // Group arithmetic: worst case 16*4095 fits in 16 bits.
    always_comb begin
        sum_c  = acc + ACC_W'(bus.sample[11:0]);
        avg_c  = 12'(sum_c >> AVG_LOG2);
        last_c = bus.sample_valid && (&cnt);
    end

    // Accumulator, sample counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            disp      <= '0;
        end else begin
            avg_valid <= 1'b0;
            if (last_c) begin
                acc       <= '0;
                cnt       <= '0;
                avg_out   <= avg_c;
                avg_valid <= 1'b1;
                disp      <= {4'h0, avg_c};
            end else if (bus.sample_valid) begin
                acc <= sum_c;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next digit index and its segment pattern; seg reads the registered
    // disp, so a fresh result shows on the lit digit one clk later.
    always_comb begin
        idx_next_c = idx;
        if (refresh == REF_LAST) begin
            idx_next_c = idx + 2'd1;
        end
        nib_c = 4'(disp >> {idx_next_c, 2'b00});
        seg_next_c = 7'b1000000;
        case (nib_c)
            4'h0: seg_next_c = 7'b1000000;
            4'h1: seg_next_c = 7'b1111001;
            4'h2: seg_next_c = 7'b0100100;
            4'h3: seg_next_c = 7'b0110000;
            4'h4: seg_next_c = 7'b0011001;
            4'h5: seg_next_c = 7'b0010010;
            4'h6: seg_next_c = 7'b0000010;
            4'h7: seg_next_c = 7'b1111000;
            4'h8: seg_next_c = 7'b0000000;
            4'h9: seg_next_c = 7'b0010000;
            4'hA: seg_next_c = 7'b0001000;
            4'hB: seg_next_c = 7'b0000011;
            4'hC: seg_next_c = 7'b1000110;
            4'hD: seg_next_c = 7'b0100001;
            4'hE: seg_next_c = 7'b0000110;
            4'hF: seg_next_c = 7'b0001110;
            default: seg_next_c = 7'b1000000;
        endcase
    end

    // Display scan: an and seg switch together with idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh <= '0;
            idx     <= 2'd0;
            an      <= 4'b1110;
            seg     <= 7'b1000000;
            dp      <= 1'b1;
        end else begin
            refresh <= (refresh == REF_LAST) ? '0 : refresh + REF_W'(1);
            idx     <= idx_next_c;
            an      <= ~(4'b0001 << idx_next_c);
            seg     <= seg_next_c;
            dp      <= 1'b1;
        end
    end

    assign bus.avg_out   = avg_out;
    assign bus.avg_valid = avg_valid;
    assign bus.an        = an;
    assign bus.seg       = seg;
    assign bus.dp        = dp;

endmodule
